// File: rtl/frac_period_meter.sv
// Measures the period of an asynchronous pulse train over a 2^FSZE-period window and reports the
// windowed sum plus a clamped fractional offset from a nominal integer period N.
module frac_period_meter #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned FSZE  = 3
) (
    input  logic                  sys_clk,
    input  logic                  sync_rst_n,
    input  logic                  pulse_in,
    input  logic [WIDTH-1:0]      N,
    output logic [WIDTH+FSZE-1:0] period_sum,
    output logic [WIDTH-1:0]      mf,
    output logic                  meas_valid,
    output logic                  mf_sat,
    output logic                  timeout,
    output logic                  locked
);

    localparam int unsigned SW = WIDTH + FSZE;
    localparam int unsigned MW = WIDTH + FSZE + 2;

    localparam logic [WIDTH-1:0] CntMax  = '1;
    localparam logic [FSZE-1:0]  WinLast = '1;

    localparam logic signed [MW-1:0] MfMax = {{(FSZE+3){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [MW-1:0] MfMin = {{(FSZE+3){1'b1}}, {(WIDTH-1){1'b0}}};

    localparam logic StArm = 1'b0;
    localparam logic StAcc = 1'b1;

    logic [2:0]       sync_q;
    logic             edge_det;
    logic             state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    acc_q, acc_d;
    logic [FSZE-1:0]  win_q, win_d;
    logic [SW-1:0]    period_sum_q, period_sum_d;
    logic [WIDTH-1:0] mf_q, mf_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;

    logic [SW-1:0]           sum;
    logic signed [MW-1:0]    diff;

    // Two synchronizer stages, the third flop only serves rising-edge detection.
    assign edge_det = sync_q[1] & ~sync_q[2];

    assign sum  = acc_q + SW'(cnt_q);
    assign diff = signed'({2'b00, sum}) - signed'({2'b00, N, {FSZE{1'b0}}});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        win_d        = win_q;
        period_sum_d = period_sum_q;
        mf_d         = mf_q;
        sat_d        = sat_q;
        locked_d     = locked_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            StArm: begin
                cnt_d = '0;
                if (edge_det) begin
                    state_d = StAcc;
                    cnt_d   = WIDTH'(1);
                    acc_d   = '0;
                    win_d   = '0;
                end
            end
            StAcc: begin
                // An edge coinciding with the counter limit is a valid period, not a timeout.
                if (edge_det) begin
                    cnt_d = WIDTH'(1);
                    win_d = win_q + 1'b1;
                    if (win_q == WinLast) begin
                        acc_d        = '0;
                        period_sum_d = sum;
                        valid_d      = 1'b1;
                        locked_d     = 1'b1;
                        if (diff > MfMax) begin
                            mf_d  = MfMax[WIDTH-1:0];
                            sat_d = 1'b1;
                        end else if (diff < MfMin) begin
                            mf_d  = MfMin[WIDTH-1:0];
                            sat_d = 1'b1;
                        end else begin
                            mf_d  = diff[WIDTH-1:0];
                            sat_d = 1'b0;
                        end
                    end else begin
                        acc_d = sum;
                    end
                end else if (cnt_q == CntMax) begin
                    state_d   = StArm;
                    cnt_d     = '0;
                    acc_d     = '0;
                    win_d     = '0;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StArm;
        endcase
    end

    always_ff @(negedge sys_clk) begin
        if (!sync_rst_n) begin
            sync_q       <= '0;
            state_q      <= StArm;
            cnt_q        <= '0;
            acc_q        <= '0;
            win_q        <= '0;
            period_sum_q <= '0;
            mf_q         <= '0;
            valid_q      <= 1'b0;
            sat_q        <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], pulse_in};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            win_q        <= win_d;
            period_sum_q <= period_sum_d;
            mf_q         <= mf_d;
            valid_q      <= valid_d;
            sat_q        <= sat_d;
            timeout_q    <= timeout_d;
            locked_q     <= locked_d;
        end
    end

    assign period_sum = period_sum_q;
    assign mf         = mf_q;
    assign meas_valid = valid_q;
    assign mf_sat     = sat_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_frac_period_meter.sv
// Directed bench for frac_period_meter (WIDTH=10 keeps the timeout and saturation runs short);
// expected window results are queued as stimulus is issued and checked by a separate monitor.
module tb_frac_period_meter;

    localparam int W = 10;
    localparam int F = 3;

    logic             sys_clk;
    logic             sync_rst_n;
    logic             pulse_in;
    logic [W-1:0]     N;
    logic [W+F-1:0]   period_sum;
    logic [W-1:0]     mf;
    logic             meas_valid;
    logic             mf_sat;
    logic             timeout;
    logic             locked;

    frac_period_meter #(
        .WIDTH(W),
        .FSZE (F)
    ) dut (
        .sys_clk   (sys_clk),
        .sync_rst_n(sync_rst_n),
        .pulse_in  (pulse_in),
        .N         (N),
        .period_sum(period_sum),
        .mf        (mf),
        .meas_valid(meas_valid),
        .mf_sat    (mf_sat),
        .timeout   (timeout),
        .locked    (locked)
    );

    typedef struct {
        int sum;
        int mfv;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_valid_cyc = 0;
    int   to_cnt  = 0;
    bit   to_seen = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void push(input int s, input int m, input int sat);
        exp_t e;
        e.sum = s;
        e.mfv = m;
        e.sat = sat;
        exp_q.push_back(e);
    endfunction

    // Rising edge now, next rising edge p cycles later; N changes well after any strobe settles.
    task automatic one_period(input int p, input int nval);
        int h;
        h = p / 2;
        pulse_in = 1'b1;
        repeat (h) @(posedge sys_clk);
        N = W'(nval);
        pulse_in = 1'b0;
        repeat (p - h) @(posedge sys_clk);
    endtask

    // Monitor: DUT updates on negedge, so sample on posedge.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (meas_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got sum %0d mf %0d, expected none",
                         period_sum, $signed(mf));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("period_sum", int'(period_sum), e.sum);
                check("mf", int'($signed(mf)), e.mfv);
                check("mf_sat", int'(mf_sat), e.sat);
                check("locked_at_strobe", int'(locked), 1);
            end
            last_valid_cyc <= cyc;
        end
        if (timeout) begin
            to_seen = 1'b1;
            to_cnt++;
            check("timeout_delay", cyc - last_valid_cyc, 1023);
            check("locked_after_timeout", int'(locked), 0);
            check("sum_hold", int'(period_sum), 8184);
            check("mf_hold", int'($signed(mf)), 0);
        end
    end

    initial begin
        int pat[8];
        pat = '{101, 101, 101, 100, 100, 100, 100, 100};
        sync_rst_n = 1'b0;
        pulse_in   = 1'b0;
        N          = W'(100);
        repeat (3) @(posedge sys_clk);
        check("rst_sum", int'(period_sum), 0);
        check("rst_mf", int'(mf), 0);
        check("rst_flags", int'({meas_valid, mf_sat, timeout, locked}), 0);
        sync_rst_n = 1'b1;
        repeat (4) @(posedge sys_clk);

        // Steady period 100.
        push(800, 0, 0);
        push(800, 0, 0);
        for (int i = 0; i < 16; i++) one_period(100, 100);

        // 3x101 + 5x100 -> 100.375.
        push(803, 3, 0);
        push(803, 3, 0);
        for (int i = 0; i < 16; i++) one_period(pat[i % 8], 100);

        // Period 97, then N moved to 97 mid-window.
        push(776, -24, 0);
        for (int i = 0; i < 8; i++) one_period(97, 100);
        push(776, 0, 0);
        for (int i = 0; i < 8; i++) one_period(97, (i < 3) ? 100 : 97);

        // Positive and negative clamp.
        push(800, 511, 1);
        for (int i = 0; i < 8; i++) one_period(100, 0);
        push(80, -512, 1);
        for (int i = 0; i < 8; i++) one_period(10, 1000);

        // Periods exactly at the counter limit: edge wins, no timeout.
        push(8184, 0, 0);
        for (int i = 0; i < 8; i++) one_period(1023, 1023);

        // Closing edge, then silence until timeout.
        pulse_in = 1'b1;
        repeat (5) @(posedge sys_clk);
        pulse_in = 1'b0;
        for (int i = 0; i < 1200 && !to_seen; i++) @(posedge sys_clk);
        check("timeout_seen", int'(to_seen), 1);
        @(posedge sys_clk);
        check("timeout_one_cycle", int'(timeout), 0);
        repeat (10) @(posedge sys_clk);

        // Relock: one arming edge plus eight periods.
        push(800, 0, 0);
        for (int i = 0; i < 9; i++) one_period(100, 100);
        for (int i = 0; i < 4; i++) one_period(100, 100);

        // Reset after the fifth edge of the current window.
        pulse_in = 1'b1;
        repeat (5) @(posedge sys_clk);
        check("locked_before_reset", int'(locked), 1);
        sync_rst_n = 1'b0;
        @(posedge sys_clk);
        check("midrst_sum", int'(period_sum), 0);
        check("midrst_mf", int'(mf), 0);
        check("midrst_flags", int'({meas_valid, mf_sat, timeout, locked}), 0);
        pulse_in = 1'b0;
        repeat (3) @(posedge sys_clk);
        sync_rst_n = 1'b1;
        repeat (4) @(posedge sys_clk);
        push(800, 0, 0);
        for (int i = 0; i < 9; i++) one_period(100, 100);
        repeat (20) @(posedge sys_clk);

        check("strobes_pending", exp_q.size(), 0);
        check("timeout_count", to_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
